// File: rtl/fft_pkg.sv
// Shared FFT helpers: twiddle generation, saturation and the default-width complex sample type.
package fft_pkg;

    localparam int  OW_DEF = 14;
    localparam real PI     = 3.14159265358979323846;

    typedef struct packed {
        logic signed [OW_DEF-1:0] re;
        logic signed [OW_DEF-1:0] im;
    } cplx_t;

    // Q2.(tw-2) cosine of 2*pi*e/n, rounded to nearest.
    function automatic int tw_cos(input int e, input int n, input int tw);
        real r;
        r = $cos(2.0 * PI * real'(e) / real'(n)) * real'(1 << (tw - 2));
        return int'($floor(r + 0.5));
    endfunction

    function automatic int tw_sin(input int e, input int n, input int tw);
        real r;
        r = $sin(2.0 * PI * real'(e) / real'(n)) * real'(1 << (tw - 2));
        return int'($floor(r + 0.5));
    endfunction

    function automatic longint sat(input longint x, input int ow);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -(longint'(1) <<< (ow - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Registered (cos, sin) lookup for exponents 0..N/2-1; one cycle of read latency.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int N  = 16,
    parameter int TW = 12,
    parameter int AW = $clog2(N / 2)
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic [AW-1:0]        i_addr,
    output logic signed [TW-1:0] o_cos,
    output logic signed [TW-1:0] o_sin
);

    localparam int DEPTH = N / 2;

    logic signed [TW-1:0] w_cos [DEPTH];
    logic signed [TW-1:0] w_sin [DEPTH];
    logic signed [TW-1:0] r_cos;
    logic signed [TW-1:0] r_sin;

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        assign w_cos[g] = TW'(tw_cos(g, N, TW));
        assign w_sin[g] = TW'(tw_sin(g, N, TW));
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_cos <= w_cos[i_addr];
            r_sin <= w_sin[i_addr];
        end
    end

    assign o_cos = r_cos;
    assign o_sin = r_sin;

endmodule

// File: rtl/twiddle_mult.sv
// SDF radix-2 DIF inter-stage rotator: rotates the second half of each 2*DLY frame by W_N^(k*STRIDE).
module twiddle_mult
    import fft_pkg::*;
#(
    parameter int DW  = 14,
    parameter int OW  = 14,
    parameter int TW  = 12,
    parameter int N   = 16,
    parameter int DLY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic                 sync_in,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 valid_out,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im
);

    localparam int FRAME  = 2 * DLY;
    localparam int CW     = $clog2(FRAME);
    localparam int STRIDE = N / FRAME;
    localparam int EW     = $clog2(N / 2);
    localparam int PW     = DW + TW;
    localparam int SW     = PW + 1;
    localparam logic signed [SW-1:0] RND = SW'(longint'(1) << (TW - 3));

    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_idx;
    logic [EW-1:0]        w_e;
    logic signed [TW-1:0] w_c;
    logic signed [TW-1:0] w_s;

    logic                 r_v1, r_v2, r_v3;
    logic signed [DW-1:0] r_a, r_b;
    logic signed [PW-1:0] r_ac, r_bs, r_bc, r_as;
    logic signed [SW-1:0] w_re_sum, w_im_sum, w_re_sh, w_im_sh;
    logic signed [OW-1:0] r_re, r_im;

    // A qualified sync forces this sample to frame index 0.
    always_comb begin
        w_idx = (valid_in && sync_in) ? '0 : r_cnt;
        if (int'(w_idx) < DLY) w_e = '0;
        else                   w_e = EW'((int'(w_idx) - DLY) * STRIDE);
    end

    always_ff @(posedge clk) begin
        if (rst)           r_cnt <= '0;
        else if (valid_in) r_cnt <= w_idx + CW'(1);
    end

    twiddle_rom #(.N(N), .TW(TW)) u_rom (
        .clk    (clk),
        .i_en   (valid_in),
        .i_addr (w_e),
        .o_cos  (w_c),
        .o_sin  (w_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= valid_in;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_a <= in_re;
            r_b <= in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (r_v1) begin
            r_ac <= r_a * w_c;
            r_bs <= r_b * w_s;
            r_bc <= r_b * w_c;
            r_as <= r_a * w_s;
        end
    end

    // (a+jb)(c-js): round half-up back to the input scale before saturating.
    always_comb begin
        w_re_sum = SW'(r_ac) + SW'(r_bs) + RND;
        w_im_sum = SW'(r_bc) - SW'(r_as) + RND;
        w_re_sh  = w_re_sum >>> (TW - 2);
        w_im_sh  = w_im_sum >>> (TW - 2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_re <= '0;
            r_im <= '0;
        end else if (r_v2) begin
            r_re <= OW'(sat(longint'(w_re_sh), OW));
            r_im <= OW'(sat(longint'(w_im_sh), OW));
        end
    end

    assign valid_out = r_v3;
    assign out_re    = r_re;
    assign out_im    = r_im;

endmodule

// File: doc/twiddle_mult.md
Name: twiddle_mult

Overview:
- Radix-2 SDF DIF inter-stage rotator, placed directly downstream of each butterfly stage and upstream of the next.
- Consumes the butterfly's sum/delayed-difference output stream and counts valid samples modulo the stage frame (2*DLY).
- Multiplies the second half-frame by W_N^(k*STRIDE); the first half-frame passes through unrotated.
- Fully pipelined: 3-cycle latency, one sample per valid cycle, no backpressure.

Parameters:
- DW, 14: input component width (signed); equals the upstream butterfly output width.
- OW, 14: output component width (signed); must satisfy OW <= DW+1.
- TW, 12: twiddle component width (signed), format Q2.(TW-2); +1.0 = 2^(TW-2).
- N, 16: full FFT length, power of 2, N >= 4.
- DLY, 4: this stage's butterfly delay; frame length = 2*DLY, power of 2, 2*DLY <= N.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_in  in  1  in_re/in_im/sync_in qualify this cycle
- sync_in  in  1  with valid_in: this sample is frame index 0
- in_re  in  DW  real input, signed
- in_im  in  DW  imag input, signed
- valid_out  out  1  out_re/out_im valid
- out_re  out  OW  real output, signed
- out_im  out  OW  imag output, signed

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All state is updated on posedge clk only.
- Reset:
  - valid_out=0, out_re=0, out_im=0.
  - Frame counter cnt=0.
  - All pipeline valid bits cleared.
  - Reset mid-frame discards in-flight samples; no valid_out for them afterwards.
- Frame counter cnt (log2(2*DLY) bits):
  - Sampled index idx = (valid_in && sync_in) ? 0 : cnt.
  - On valid_in: cnt <= idx+1, wrapping 2*DLY-1 -> 0.
  - No valid_in: cnt holds. Gaps do not advance the frame.
  - sync_in without valid_in is ignored.
- Twiddle exponent, with STRIDE = N/(2*DLY):
  - idx < DLY: e = 0.
  - Otherwise: e = (idx-DLY)*STRIDE, range 0..N/2-STRIDE.
- Twiddle values:
  - c = round(cos(2*pi*e/N) * 2^(TW-2)).
  - s = round(sin(2*pi*e/N) * 2^(TW-2)).
  - W = c - j*s.
- Pipeline (each stage's data registers load only when that stage's valid bit is set; otherwise they hold):
  - S1: register in_re/in_im, c, s, valid.
  - S2: register the four products a*c, b*s, b*c, a*s. Each product is DW+TW bits.
  - S3:
    - re = a*c + b*s; im = b*c - a*s (DW+TW+1 bits).
    - Round half-up: add 2^(TW-3), arithmetic shift right by TW-2.
    - Saturate to OW bits: max 2^(OW-1)-1, min -2^(OW-1).
    - Register into out_re/out_im with valid_out.
- Latency: sample accepted at edge T appears with valid_out=1 after edge T+3. Back-to-back throughput is 1/cycle.
- When valid_out=0, out_re/out_im hold their last values.
- e=0 (c=2^(TW-2), s=0) must reproduce the input exactly (the rounding offset truncates away), sign-extended/saturated to OW.
- e=N/4 gives (a+jb)*(-j) = b - j*a exactly. -a at a = -2^(DW-1) saturates only if OW = DW.

Decomposition:
- Package fft_pkg:
  - Elaboration-time function tw_cos(e,N,TW) and tw_sin(e,N,TW) using $cos/$sin with rounding.
  - Function sat(x, OW).
  - typedef cplx_t (re/im struct) parameterised via localparams for the default widths.
- Sub-module twiddle_rom:
  - Parameters N, TW.
  - Registered read of (c,s) for address e; 1-cycle latency, aligned to S1.
  - Contents generated from the fft_pkg functions in an initial/generate loop.

Test Plan:
- Defaults (N=16, DLY=4, TW=12, c(0)=1024). rst held 3 cycles mid-stream -> valid_out=0, out_re=out_im=0; first post-reset valid sample is idx 0.
- Eight consecutive samples, all (100,50), with sync_in on the first:
  - idx 0..3 -> (100,50).
  - idx 4 (e=0) -> (100,50).
  - idx 5 (e=2, c=s=724) -> (106,-35).
  - idx 6 (e=4) -> (50,-100).
  - idx 7 (e=6) -> (-35,-106).
  - Each output appears 3 cycles after its input.
- Same 8 samples with 2-cycle valid_in gaps inserted -> identical output sequence; valid_out pulses keep the same spacing as the input.
- sync_in asserted at cnt=5 -> that sample uses e=0 and outputs its input unchanged; the next sample uses idx 1 (e=0).
- Saturation: input (8191,8191) at idx 5 -> re = round(8191*1448/1024) = 11583 -> out_re=8191; out_im=0.
- Corner: input (-8192,0) at idx 6 (e=4) -> out_re=0, out_im=8191 (saturated from +8192).
